shot_flash_ctrl: RTL and testbench

SHOT_FLASH_CTRL -- requirements
Module: shot_flash_ctrl

---
 rtl/shot_flash_ctrl_if.sv | 43 ++++
 rtl/shot_flash_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_shot_flash_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shot_flash_ctrl_if.sv
// Pixel-side interface of the light-gun flash controller.
// The video pipeline drives the slave inputs and takes back the colour overrides and the shot result.
interface shot_flash_ctrl_if;
    logic       vs;
    logic       display_en;
    logic       trigger;
    logic [2:0] bg_idx;
    logic       duck_on;
    logic [2:0] color_idx;
    logic       force_black;
    logic       force_white;
    logic       busy;
    logic       hit_valid;
    logic       hit;

    modport master (
        output vs,
        output display_en,
        output trigger,
        output bg_idx,
        output duck_on,
        input  color_idx,
        input  force_black,
        input  force_white,
        input  busy,
        input  hit_valid,
        input  hit
    );

    modport slave (
        input  vs,
        input  display_en,
        input  trigger,
        input  bg_idx,
        input  duck_on,
        output color_idx,
        output force_black,
        output force_white,
        output busy,
        output hit_valid,
        output hit
    );
endinterface

// File: rtl/shot_flash_ctrl.sv
// Light-gun shot sequencer: on a trigger edge it blanks the screen, highlights live ducks
// in white for a few frames, reports hit/miss, then ignores the trigger for a cooldown period.
module shot_flash_ctrl #(
    parameter int FLASH_FRAMES    = 1,
    parameter int TARGET_FRAMES   = 1,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst,
    shot_flash_ctrl_if.slave bus
);

    localparam int         SYNC_STAGES = 2;
    localparam logic [3:0] FLASH_LOAD  = 4'(FLASH_FRAMES - 1);
    localparam logic [3:0] TARGET_LOAD = 4'(TARGET_FRAMES - 1);
    localparam logic [3:0] COOL_LOAD   = 4'(COOLDOWN_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        BLACK    = 3'd2,
        TARGET   = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    // Trigger synchroniser chain, one flop per stage.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) stage_reg <= 1'b0;
                    else     stage_reg <= bus.trigger;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) stage_reg <= 1'b0;
                    else     stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    logic trig_sync;
    assign trig_sync = g_sync[SYNC_STAGES-1].stage_reg;

    logic                   trig_prev_reg;
    logic                   trig_armed_reg;
    logic [SYNC_STAGES-1:0] settle_reg;
    logic                   vs_prev_reg;

    // The edge detector is only armed once the synchroniser has carried a real low sample,
    // so a trigger held through reset release never looks like a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_prev_reg  <= 1'b0;
            trig_armed_reg <= 1'b0;
            settle_reg     <= '0;
            vs_prev_reg    <= 1'b1;
        end else begin
            trig_prev_reg <= trig_sync;
            settle_reg    <= {settle_reg[SYNC_STAGES-2:0], 1'b1};
            vs_prev_reg   <= bus.vs;
            if (settle_reg[SYNC_STAGES-1] && !trig_sync) begin
                trig_armed_reg <= 1'b1;
            end
        end
    end

    logic shot_req;
    logic frame_start;
    logic pixel_hit;

    assign shot_req    = trig_sync & ~trig_prev_reg & trig_armed_reg;
    assign frame_start = vs_prev_reg & ~bus.vs;
    assign pixel_hit   = bus.duck_on & bus.display_en;

    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic       hit_latch_reg;

    logic [2:0] pix_color_next;
    logic       pix_black_next;
    logic       pix_white_next;

    // Pixel override decode from the pre-edge state; blanking always yields the plain index 1.
    always_comb begin
        pix_color_next = 3'b001;
        pix_black_next = 1'b0;
        pix_white_next = 1'b0;
        if (bus.display_en) begin
            case (state_reg)
                BLACK: begin
                    pix_black_next = 1'b1;
                end
                TARGET: begin
                    if (bus.duck_on) begin
                        pix_color_next = bus.bg_idx;
                        pix_white_next = 1'b1;
                    end else begin
                        pix_black_next = 1'b1;
                    end
                end
                default: begin
                    pix_color_next = bus.bg_idx;
                end
            endcase
        end
    end

    logic [2:0] color_idx_reg;
    logic       force_black_reg;
    logic       force_white_reg;
    logic       busy_reg;
    logic       hit_valid_reg;
    logic       hit_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            hit_latch_reg   <= 1'b0;
            color_idx_reg   <= 3'b000;
            force_black_reg <= 1'b0;
            force_white_reg <= 1'b0;
            busy_reg        <= 1'b0;
            hit_valid_reg   <= 1'b0;
            hit_reg         <= 1'b0;
        end else begin
            color_idx_reg   <= pix_color_next;
            force_black_reg <= pix_black_next;
            force_white_reg <= pix_white_next;
            hit_valid_reg   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // A coincident frame start is ignored here: BLACK waits for the next one.
                    if (shot_req) begin
                        state_reg <= ARM;
                        busy_reg  <= 1'b1;
                    end
                end
                ARM: begin
                    if (frame_start) begin
                        state_reg <= BLACK;
                        cnt_reg   <= FLASH_LOAD;
                    end
                end
                BLACK: begin
                    if (frame_start) begin
                        if (cnt_reg == 4'd0) begin
                            state_reg     <= TARGET;
                            cnt_reg       <= TARGET_LOAD;
                            hit_latch_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg - 4'd1;
                        end
                    end
                end
                TARGET: begin
                    if (pixel_hit) begin
                        hit_latch_reg <= 1'b1;
                    end
                    if (frame_start) begin
                        if (cnt_reg == 4'd0) begin
                            state_reg     <= COOLDOWN;
                            cnt_reg       <= COOL_LOAD;
                            hit_valid_reg <= 1'b1;
                            hit_reg       <= hit_latch_reg | pixel_hit;
                        end else begin
                            cnt_reg <= cnt_reg - 4'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_start) begin
                        if (cnt_reg == 4'd0) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg - 4'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 4'd0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.color_idx   = color_idx_reg;
    assign bus.force_black = force_black_reg;
    assign bus.force_white = force_white_reg;
    assign bus.busy        = busy_reg;
    assign bus.hit_valid   = hit_valid_reg;
    assign bus.hit         = hit_reg;

endmodule

// File: tb/tb_shot_flash_ctrl.sv
// Directed bench for shot_flash_ctrl: a default instance and a 3/2/1 instance share stimulus;
// each frame applies table rows on visible pixels and checks the registered outputs.
module tb_shot_flash_ctrl;

    localparam int L = 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_ARM   = 1;
    localparam int PH_BLACK = 2;
    localparam int PH_TGT   = 3;
    localparam int PH_COOL  = 4;
    localparam int PH_TGT0  = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shot_flash_ctrl_if if_a ();
    shot_flash_ctrl_if if_b ();

    assign if_b.vs         = if_a.vs;
    assign if_b.display_en = if_a.display_en;
    assign if_b.trigger    = if_a.trigger;
    assign if_b.bg_idx     = if_a.bg_idx;
    assign if_b.duck_on    = if_a.duck_on;

    shot_flash_ctrl u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    shot_flash_ctrl #(
        .FLASH_FRAMES    (3),
        .TARGET_FRAMES   (2),
        .COOLDOWN_FRAMES (1)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    typedef struct {
        logic       de;
        logic       duck;
        logic [2:0] bg;
        logic [2:0] ec;
        logic       efb;
        logic       efw;
    } vec_t;

    vec_t tbl [24];

    int n_vec = 0;
    int n_bad = 0;
    int hv_a  = 0;
    int hv_b  = 0;
    bit sel   = 1'b0;

    logic [2:0] o_col;
    logic       o_fb, o_fw, o_busy, o_hv, o_hit;
    assign o_col  = sel ? if_b.color_idx   : if_a.color_idx;
    assign o_fb   = sel ? if_b.force_black : if_a.force_black;
    assign o_fw   = sel ? if_b.force_white : if_a.force_white;
    assign o_busy = sel ? if_b.busy        : if_a.busy;
    assign o_hv   = sel ? if_b.hit_valid   : if_a.hit_valid;
    assign o_hit  = sel ? if_b.hit         : if_a.hit;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hv_a <= 0;
            hv_b <= 0;
        end else begin
            if (if_a.hit_valid === 1'b1) hv_a <= hv_a + 1;
            if (if_b.hit_valid === 1'b1) hv_b <= hv_b + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int i, input logic de, input logic duck, input logic [2:0] bg,
                           input logic [2:0] ec, input logic efb, input logic efw);
        tbl[i].de   = de;
        tbl[i].duck = duck;
        tbl[i].bg   = bg;
        tbl[i].ec   = ec;
        tbl[i].efb  = efb;
        tbl[i].efw  = efw;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " a.color"}, 32'(if_a.color_idx), 32'd0);
        chk({nm, " a.fb"},    32'(if_a.force_black), 32'd0);
        chk({nm, " a.fw"},    32'(if_a.force_white), 32'd0);
        chk({nm, " a.busy"},  32'(if_a.busy), 32'd0);
        chk({nm, " a.hv"},    32'(if_a.hit_valid), 32'd0);
        chk({nm, " a.hit"},   32'(if_a.hit), 32'd0);
        chk({nm, " b.color"}, 32'(if_b.color_idx), 32'd0);
        chk({nm, " b.busy"},  32'(if_b.busy), 32'd0);
        chk({nm, " b.hv"},    32'(if_b.hit_valid), 32'd0);
    endtask

    // Asynchronous assertion between clock edges, then held for two edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk_zero("rst async");
        step();
        chk_zero("rst held1");
        step();
        chk_zero("rst held2");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    // One frame: vs low for k=0..1, visible window k=4..13 driven from the phase's table rows.
    task automatic frame(input int ph, input bit de_kill, input int t_on, input int t_off,
                         input bit bs, input bit be, input bit hv_exp, input bit hit_exp,
                         input int cut);
        for (int k = 0; k < cut; k++) begin
            vec_t       r;
            logic [2:0] ec;
            logic       efb, efw;
            if (k == t_on)  if_a.trigger = 1'b1;
            if (k == t_off) if_a.trigger = 1'b0;
            if_a.vs = (k < 2) ? 1'b0 : 1'b1;
            ec  = 3'b001;
            efb = 1'b0;
            efw = 1'b0;
            if (k >= 4 && k < 14 && !de_kill) begin
                r = tbl[ph*4 + (k-4)%4];
                if_a.display_en = r.de;
                if_a.duck_on    = r.duck;
                if_a.bg_idx     = r.bg;
                ec  = r.ec;
                efb = r.efb;
                efw = r.efw;
            end else begin
                if_a.display_en = 1'b0;
                if_a.duck_on    = de_kill;
                if_a.bg_idx     = 3'b101;
            end
            step();
            chk($sformatf("color ph%0d k%0d", ph, k), 32'(o_col), 32'(ec));
            chk($sformatf("force_black ph%0d k%0d", ph, k), 32'(o_fb), 32'(efb));
            chk($sformatf("force_white ph%0d k%0d", ph, k), 32'(o_fw), 32'(efw));
            chk($sformatf("hit_valid ph%0d k%0d", ph, k), 32'(o_hv), 32'((k == 0) && hv_exp));
            if (k == 0 && hv_exp) chk($sformatf("hit ph%0d", ph), 32'(o_hit), 32'(hit_exp));
            if (k == 1)     chk($sformatf("busy start ph%0d", ph), 32'(o_busy), 32'(bs));
            if (k == L - 1) chk($sformatf("busy end ph%0d", ph), 32'(o_busy), 32'(be));
        end
    endtask

    initial begin
        //           idx de duck bg     -> color  fb    fw
        set_row( 0, 1, 0, 3'd5, 3'd5, 0, 0);
        set_row( 1, 1, 1, 3'd3, 3'd3, 0, 0);
        set_row( 2, 0, 1, 3'd6, 3'd1, 0, 0);
        set_row( 3, 1, 0, 3'd7, 3'd7, 0, 0);
        set_row( 4, 1, 0, 3'd2, 3'd2, 0, 0);
        set_row( 5, 1, 1, 3'd4, 3'd4, 0, 0);
        set_row( 6, 0, 0, 3'd7, 3'd1, 0, 0);
        set_row( 7, 1, 0, 3'd0, 3'd0, 0, 0);
        set_row( 8, 1, 0, 3'd5, 3'd1, 1, 0);
        set_row( 9, 1, 1, 3'd6, 3'd1, 1, 0);
        set_row(10, 0, 1, 3'd2, 3'd1, 0, 0);
        set_row(11, 1, 0, 3'd7, 3'd1, 1, 0);
        set_row(12, 1, 1, 3'd6, 3'd6, 0, 1);
        set_row(13, 1, 0, 3'd5, 3'd1, 1, 0);
        set_row(14, 0, 1, 3'd3, 3'd1, 0, 0);
        set_row(15, 1, 1, 3'd2, 3'd2, 0, 1);
        set_row(16, 1, 1, 3'd4, 3'd4, 0, 0);
        set_row(17, 1, 0, 3'd6, 3'd6, 0, 0);
        set_row(18, 0, 0, 3'd5, 3'd1, 0, 0);
        set_row(19, 1, 1, 3'd1, 3'd1, 0, 0);
        set_row(20, 1, 0, 3'd6, 3'd1, 1, 0);
        set_row(21, 0, 1, 3'd7, 3'd1, 0, 0);
        set_row(22, 1, 0, 3'd3, 3'd1, 1, 0);
        set_row(23, 1, 0, 3'd4, 3'd1, 1, 0);

        if_a.vs         = 1'b1;
        if_a.display_en = 1'b0;
        if_a.trigger    = 1'b0;
        if_a.bg_idx     = 3'd0;
        if_a.duck_on    = 1'b0;
        sel = 1'b0;

        // Default instance: full sequence with a duck hit, plus ignored triggers.
        do_reset();
        frame(PH_IDLE,  0, -1, -1, 0, 0, 0, 0, L);
        frame(PH_IDLE,  0,  2,  5, 0, 1, 0, 0, L);
        frame(PH_BLACK, 0,  2,  5, 1, 1, 0, 0, L);
        frame(PH_TGT,   0, -1, -1, 1, 1, 0, 0, L);
        frame(PH_COOL,  0, -1, -1, 1, 1, 1, 1, L);
        for (int i = 2; i <= 8; i++)
            frame(PH_COOL, 0, (i == 4) ? 2 : -1, (i == 4) ? 5 : -1, 1, 1, 0, 0, L);
        frame(PH_IDLE,  0, -1, -1, 0, 0, 0, 0, L);
        chk("hit_valid count seq1", 32'(hv_a), 32'd1);

        // Miss: no duck pixels during the target frame.
        frame(PH_IDLE,  0,  2,  5, 0, 1, 0, 0, L);
        frame(PH_BLACK, 0, -1, -1, 1, 1, 0, 0, L);
        frame(PH_TGT0,  0, -1, -1, 1, 1, 0, 0, L);
        frame(PH_COOL,  0, -1, -1, 1, 1, 1, 0, L);
        for (int i = 2; i <= 8; i++) frame(PH_COOL, 0, -1, -1, 1, 1, 0, 0, L);
        frame(PH_IDLE,  0, -1, -1, 0, 0, 0, 0, L);
        chk("hit_valid count seq2", 32'(hv_a), 32'd2);

        // Shot request coincident with frame start: a full ARM frame precedes BLACK.
        frame(PH_IDLE,  0, L-2, -1, 0, 0, 0, 0, L);
        frame(PH_ARM,   0, -1,  1, 1, 1, 0, 0, L);
        frame(PH_BLACK, 1, -1, -1, 1, 1, 0, 0, L);
        frame(PH_TGT,   1, -1, -1, 1, 1, 0, 0, L);
        frame(PH_COOL,  0, -1, -1, 1, 1, 1, 0, L);
        for (int i = 2; i <= 8; i++) frame(PH_COOL, 0, -1, -1, 1, 1, 0, 0, L);
        frame(PH_IDLE,  0, -1, -1, 0, 0, 0, 0, L);
        chk("hit_valid count seq3", 32'(hv_a), 32'd3);

        // Reset mid-target with the trigger held high through release.
        frame(PH_IDLE,  0,  2,  5, 0, 1, 0, 0, L);
        frame(PH_BLACK, 0, -1, -1, 1, 1, 0, 0, L);
        frame(PH_TGT,   0, -1, -1, 1, 1, 0, 0, 8);
        if_a.trigger = 1'b1;
        do_reset();
        frame(PH_IDLE,  0, -1, -1, 0, 0, 0, 0, L);
        frame(PH_IDLE,  0, -1,  3, 0, 0, 0, 0, L);
        chk("hit_valid after abort", 32'(hv_a), 32'd0);
        frame(PH_IDLE,  0,  6,  9, 0, 1, 0, 0, L);

        // 3/2/1 instance: frame counts per phase.
        do_reset();
        sel = 1'b1;
        frame(PH_IDLE,  0, -1, -1, 0, 0, 0, 0, L);
        frame(PH_IDLE,  0,  2,  5, 0, 1, 0, 0, L);
        for (int i = 0; i < 3; i++) frame(PH_BLACK, 0, -1, -1, 1, 1, 0, 0, L);
        for (int i = 0; i < 2; i++) frame(PH_TGT,   0, -1, -1, 1, 1, 0, 0, L);
        frame(PH_COOL,  0, -1, -1, 1, 1, 1, 1, L);
        frame(PH_IDLE,  0, -1, -1, 0, 0, 0, 0, L);
        chk("hit_valid count b", 32'(hv_b), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
